pong_game_ctrl: RTL and testbench

Top-level game sequencer for the Pong screen. Tracks scores and decides when the ball runs or is served. Drives the game_over input of the background renderer. Sits between the frame-timing logic (frame_tick), the player start button and the ball/collision logic (miss pulses), and steps the game through idle, serve, play, point and game-over phases.

---
 rtl/pong_game_ctrl_if.sv | 41 ++++
 rtl/pong_game_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong game sequencer and its frame/button/ball neighbours.
// Optional pause signals exist only when PONG_PAUSE_EN is defined.
interface pong_game_ctrl_if;
    logic       frame_tick;
    logic       start_btn;
    logic       miss_l;
    logic       miss_r;
    logic       game_over;
    logic       ball_run;
    logic       serve_pulse;
    logic       serve_dir;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic       winner;
`ifdef PONG_PAUSE_EN
    logic       pause_btn;
    logic       paused;

    modport master (
        output frame_tick, start_btn, miss_l, miss_r, pause_btn,
        input  game_over, ball_run, serve_pulse, serve_dir,
               score_l, score_r, winner, paused
    );
    modport slave (
        input  frame_tick, start_btn, miss_l, miss_r, pause_btn,
        output game_over, ball_run, serve_pulse, serve_dir,
               score_l, score_r, winner, paused
    );
`else
    modport master (
        output frame_tick, start_btn, miss_l, miss_r,
        input  game_over, ball_run, serve_pulse, serve_dir,
               score_l, score_r, winner
    );
    modport slave (
        input  frame_tick, start_btn, miss_l, miss_r,
        output game_over, ball_run, serve_pulse, serve_dir,
               score_l, score_r, winner
    );
`endif
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: idle/serve/play/point/game-over phases, scores and serve control.
// Define PONG_PAUSE_EN to add the pause button and paused output.
module pong_game_ctrl #(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int OVER_FRAMES  = 180
) (
    input  logic             vga_clk,
    input  logic             sys_rst,
    pong_game_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_GAME_OVER
    } state_t;

    localparam logic [3:0] WIN_LIM   = 4'(WIN_SCORE);
    localparam logic [9:0] SERVE_LIM = 10'(SERVE_FRAMES);
    localparam logic [9:0] OVER_LIM  = 10'(OVER_FRAMES);

    state_t     state_q;
    logic       start_q;
    logic [9:0] cnt_q;
    logic       game_over_q;
    logic       ball_run_q;
    logic       serve_pulse_q;
    logic       serve_dir_q;
    logic [3:0] score_l_q;
    logic [3:0] score_r_q;
    logic       winner_q;

    logic       start_rise;
    logic [9:0] cnt_d;
    logic       hold;

    assign start_rise = bus.start_btn & ~start_q;
    assign cnt_d      = cnt_q + 10'd1;

`ifdef PONG_PAUSE_EN
    logic pause_q;
    logic paused_q;
    logic pause_hit;

    // A pause edge only means something while a rally is being served or played.
    assign pause_hit = bus.pause_btn & ~pause_q &
                       ((state_q == S_SERVE) || (state_q == S_PLAY));
    assign hold      = paused_q | pause_hit;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pause_q  <= 1'b0;
            paused_q <= 1'b0;
        end else begin
            pause_q <= bus.pause_btn;
            if (pause_hit) begin
                paused_q <= ~paused_q;
            end
        end
    end

    assign bus.paused = paused_q;
`else
    assign hold = 1'b0;
`endif

    // Outputs follow the state they describe, so each lags its cause by one cycle.
    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b0;
            cnt_q         <= 10'd0;
            game_over_q   <= 1'b0;
            ball_run_q    <= 1'b0;
            serve_pulse_q <= 1'b0;
            serve_dir_q   <= 1'b0;
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            winner_q      <= 1'b0;
        end else begin
            start_q       <= bus.start_btn;
            serve_pulse_q <= 1'b0;
            game_over_q   <= (state_q == S_GAME_OVER);
            ball_run_q    <= (state_q == S_PLAY) && !hold;

            case (state_q)
                S_IDLE: begin
                    if (start_rise) begin
                        score_l_q   <= 4'd0;
                        score_r_q   <= 4'd0;
                        serve_dir_q <= 1'b1;
                        cnt_q       <= 10'd0;
                        state_q     <= S_SERVE;
                    end
                end

                S_SERVE: begin
                    if (bus.frame_tick && !hold) begin
                        if (cnt_d == SERVE_LIM) begin
                            serve_pulse_q <= 1'b1;
                            cnt_q         <= 10'd0;
                            state_q       <= S_PLAY;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end

                // The serve goes toward the side that just lost the point.
                S_PLAY: begin
                    if (!hold) begin
                        case ({bus.miss_l, bus.miss_r})
                            2'b10: begin
                                score_r_q   <= score_r_q + 4'd1;
                                serve_dir_q <= 1'b0;
                                state_q     <= S_POINT;
                            end
                            2'b01: begin
                                score_l_q   <= score_l_q + 4'd1;
                                serve_dir_q <= 1'b1;
                                state_q     <= S_POINT;
                            end
                            2'b11: begin
                                state_q <= S_POINT;
                            end
                            default: begin
                                state_q <= S_PLAY;
                            end
                        endcase
                    end
                end

                S_POINT: begin
                    cnt_q <= 10'd0;
                    if (score_l_q == WIN_LIM) begin
                        winner_q <= 1'b0;
                        state_q  <= S_GAME_OVER;
                    end else if (score_r_q == WIN_LIM) begin
                        winner_q <= 1'b1;
                        state_q  <= S_GAME_OVER;
                    end else begin
                        state_q <= S_SERVE;
                    end
                end

                S_GAME_OVER: begin
                    if (start_rise || (bus.frame_tick && (cnt_d == OVER_LIM))) begin
                        cnt_q   <= 10'd0;
                        state_q <= S_IDLE;
                    end else if (bus.frame_tick) begin
                        cnt_q <= cnt_d;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.game_over   = game_over_q;
    assign bus.ball_run    = ball_run_q;
    assign bus.serve_pulse = serve_pulse_q;
    assign bus.serve_dir   = serve_dir_q;
    assign bus.score_l     = score_l_q;
    assign bus.score_r     = score_r_q;
    assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: expected score/serve records are queued as
// misses are driven and popped when the DUT serves or ends the game.
module tb_pong_game_ctrl;

    logic vga_clk = 1'b0;
    logic sys_rst;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [3:0] sl;
        logic [3:0] sr;
        logic       dir;
    } exp_t;

    exp_t       expQ[$];
    logic [3:0] mSl;
    logic [3:0] mSr;
    logic       mDir;

    pong_game_ctrl_if bus();

    pong_game_ctrl #(
        .WIN_SCORE    (5),
        .SERVE_FRAMES (60),
        .OVER_FRAMES  (180)
    ) dut (
        .vga_clk (vga_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic pulse_tick();
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
    endtask

    task automatic push_model();
        exp_t e;
        e.sl  = mSl;
        e.sr  = mSr;
        e.dir = mDir;
        expQ.push_back(e);
    endtask

    task automatic pop_compare(input string name);
        exp_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s scoreboard empty", name);
        end else begin
            e = expQ.pop_front();
            if (bus.score_l !== e.sl || bus.score_r !== e.sr || bus.serve_dir !== e.dir) begin
                errors++;
                $display("[TB] FAIL %s score/dir actual=%0d:%0d dir=%0b required=%0d:%0d dir=%0b",
                         name, bus.score_l, bus.score_r, bus.serve_dir, e.sl, e.sr, e.dir);
            end
        end
    endtask

    // Sends frame ticks until serve_pulse appears and checks the count and the launch.
    task automatic run_serve(input string name, input int expTicks);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 400) begin
            pulse_tick();
            n++;
            if (bus.serve_pulse === 1'b1) seen = 1'b1;
            else step(1);
        end
        checks++;
        if (!seen || n != expTicks) begin
            errors++;
            $display("[TB] FAIL %s serve ticks actual=%0d seen=%0b required=%0d", name, n, seen, expTicks);
        end
        checks++;
        if (bus.ball_run !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s ball_run during serve actual=%0b required=0", name, bus.ball_run);
        end
        pop_compare(name);
        step(1);
        checks++;
        if (bus.serve_pulse !== 1'b0 || bus.ball_run !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s after serve pulse=%0b run=%0b required pulse=0 run=1",
                     name, bus.serve_pulse, bus.ball_run);
        end
    endtask

    task automatic do_miss(input logic l, input logic r);
        if (l && !r) begin
            mSr  = mSr + 4'd1;
            mDir = 1'b0;
        end else if (r && !l) begin
            mSl  = mSl + 4'd1;
            mDir = 1'b1;
        end
        push_model();
        bus.miss_l = l;
        bus.miss_r = r;
        step(1);
        bus.miss_l = 1'b0;
        bus.miss_r = 1'b0;
        step(2);
    endtask

    task automatic new_game();
        mSl  = 4'd0;
        mSr  = 4'd0;
        mDir = 1'b1;
        push_model();
        bus.start_btn = 1'b1;
        step(1);
        bus.start_btn = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        step(2);
        checks++;
        if ({bus.game_over, bus.ball_run, bus.serve_pulse, bus.serve_dir,
             bus.score_l, bus.score_r, bus.winner} !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset outputs actual=%b required=0",
                     {bus.game_over, bus.ball_run, bus.serve_pulse, bus.serve_dir,
                      bus.score_l, bus.score_r, bus.winner});
        end
        sys_rst = 1'b0;
        step(2);
    endtask

    task automatic test_start_hold();
        mSl  = 4'd0;
        mSr  = 4'd0;
        mDir = 1'b1;
        push_model();
        bus.start_btn = 1'b1;
        step(1);
        for (int i = 0; i < 50; i++) begin
            pulse_tick();
            step(1);
        end
        bus.start_btn = 1'b0;
        checks++;
        if (bus.serve_dir !== 1'b1 || bus.ball_run !== 1'b0) begin
            errors++;
            $display("[TB] FAIL start_hold dir=%0b run=%0b required dir=1 run=0", bus.serve_dir, bus.ball_run);
        end
        run_serve("start_hold", 10);
    endtask

    task automatic test_points();
        do_miss(1'b0, 1'b1);
        run_serve("miss_r", 60);
        do_miss(1'b1, 1'b1);
        run_serve("double_miss", 60);
        do_miss(1'b1, 1'b0);
        run_serve("miss_l", 60);
        do_miss(1'b0, 1'b1);
        run_serve("miss_r_2", 60);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        #2;
        sys_rst = 1'b1;
        #1;
        checks++;
        if ({bus.ball_run, bus.serve_dir, bus.score_l, bus.score_r} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid async run=%0b dir=%0b score=%0d:%0d required all 0",
                     bus.ball_run, bus.serve_dir, bus.score_l, bus.score_r);
        end
        step(1);
        sys_rst = 1'b0;
        bus.miss_l = 1'b1;
        step(1);
        bus.miss_l = 1'b0;
        for (int i = 0; i < 70; i++) begin
            pulse_tick();
            if (bus.serve_pulse !== 1'b0 || bus.ball_run !== 1'b0) seen = 1'b1;
            step(1);
        end
        checks++;
        if (seen || bus.score_r !== 4'd0) begin
            errors++;
            $display("[TB] FAIL idle_ignore activity=%0b score_r=%0d required activity=0 score_r=0",
                     seen, bus.score_r);
        end
        new_game();
        run_serve("after_reset", 60);
    endtask

    task automatic test_game_over_right();
        int n = 0;
        for (int k = 0; k < 4; k++) begin
            do_miss(1'b1, 1'b0);
            run_serve("score_r_walk", 60);
        end
        do_miss(1'b1, 1'b0);
        pop_compare("final_score_r");
        checks++;
        if (bus.game_over !== 1'b1 || bus.winner !== 1'b1 || bus.ball_run !== 1'b0) begin
            errors++;
            $display("[TB] FAIL game_over_r over=%0b winner=%0b run=%0b required 1 1 0",
                     bus.game_over, bus.winner, bus.ball_run);
        end
        while (bus.game_over === 1'b1 && n < 400) begin
            pulse_tick();
            step(1);
            n++;
        end
        checks++;
        if (n != 180 || bus.score_r !== 4'd5) begin
            errors++;
            $display("[TB] FAIL over_frames actual=%0d score_r=%0d required 180 score_r=5", n, bus.score_r);
        end
    endtask

    task automatic test_game_over_left();
        new_game();
        run_serve("left_game", 60);
        for (int k = 0; k < 4; k++) begin
            do_miss(1'b0, 1'b1);
            run_serve("score_l_walk", 60);
        end
        do_miss(1'b0, 1'b1);
        pop_compare("final_score_l");
        checks++;
        if (bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin
            errors++;
            $display("[TB] FAIL game_over_l over=%0b winner=%0b required 1 0", bus.game_over, bus.winner);
        end
        bus.start_btn = 1'b1;
        step(1);
        checks++;
        if (bus.game_over !== 1'b1) begin
            errors++;
            $display("[TB] FAIL start_exit_lag over=%0b required 1", bus.game_over);
        end
        step(1);
        bus.start_btn = 1'b0;
        checks++;
        if (bus.game_over !== 1'b0 || bus.score_l !== 4'd5 || bus.score_r !== 4'd0) begin
            errors++;
            $display("[TB] FAIL start_exit over=%0b score=%0d:%0d required 0 5:0",
                     bus.game_over, bus.score_l, bus.score_r);
        end
    endtask

`ifdef PONG_PAUSE_EN
    task automatic test_pause();
        new_game();
        for (int i = 0; i < 30; i++) begin
            pulse_tick();
            step(1);
        end
        bus.pause_btn = 1'b1;
        step(1);
        bus.pause_btn = 1'b0;
        step(1);
        checks++;
        if (bus.paused !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pause_on paused=%0b required 1", bus.paused);
        end
        for (int i = 0; i < 100; i++) begin
            pulse_tick();
            step(1);
        end
        bus.pause_btn = 1'b1;
        step(1);
        bus.pause_btn = 1'b0;
        step(1);
        run_serve("pause_resume", 30);
    endtask
`endif

    initial begin
        sys_rst        = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start_btn  = 1'b0;
        bus.miss_l     = 1'b0;
        bus.miss_r     = 1'b0;
`ifdef PONG_PAUSE_EN
        bus.pause_btn  = 1'b0;
`endif
        mSl  = 4'd0;
        mSr  = 4'd0;
        mDir = 1'b0;
        test_reset();
        test_start_hold();
        test_points();
        test_reset_mid();
        test_game_over_right();
        test_game_over_left();
`ifdef PONG_PAUSE_EN
        test_pause();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
